// File: rtl/lif_neuron_multi.sv
// Multi-channel leaky integrate-and-fire neuron with per-channel short-term
// depression, adaptive clamped threshold, refractory counter and spike counter.
module lif_neuron_multi #(
   parameter int NUM_CH   = 4,
   parameter int IN_W     = 3,
   parameter int W_W      = 3,
   parameter int V_W      = 10,
   parameter int REFRAC   = 4,
   parameter int THR_UP   = 4,
   parameter int THR_DN   = 1,
   parameter int DEP_STEP = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   params_ready,
   input  logic [NUM_CH*IN_W-1:0] chan_in,
   input  logic [NUM_CH*W_W-1:0]  weight_in,
   input  logic [1:0]             leak_config,
   input  logic                   reset_mode,
   input  logic [V_W-1:0]         threshold_min,
   input  logic [V_W-1:0]         threshold_max,
   input  logic                   count_clr,
   output logic                   spike_out,
   output logic [V_W-1:0]         v_mem_out,
   output logic                   refractory,
   output logic [7:0]             spike_count
);

   localparam int S_W  = IN_W + W_W + $clog2(NUM_CH);
   localparam int N_W  = ((V_W > S_W) ? V_W : S_W) + 2;
   localparam int RC_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

   logic [V_W-1:0]  v_mem;
   logic [V_W-1:0]  thr;
   logic [RC_W-1:0] refr_cnt;
   logic [W_W-1:0]  dep [NUM_CH];

   logic                  step;
   logic [2:0]            leak;
   logic [V_W-1:0]        thr_c;
   logic [W_W-1:0]        eff_w [NUM_CH];
   logic [S_W-1:0]        sum;
   logic signed [N_W-1:0] nv_s;
   logic [V_W-1:0]        new_v;
   logic [V_W-1:0]        v_leak;
   logic [V_W:0]          thr_up_w;
   logic [V_W:0]          thr_lo_w;
   logic [V_W-1:0]        thr_spk;
   logic [V_W-1:0]        thr_idle;
   logic                  fire;

   assign step       = enable && params_ready;
   assign leak       = {1'b0, leak_config} + 3'd1;
   assign v_mem_out  = v_mem;
   assign refractory = (refr_cnt != '0);

   always_comb begin
      if (thr < threshold_min)
         thr_c = threshold_min;
      else if (thr > threshold_max)
         thr_c = threshold_max;
      else
         thr_c = thr;
   end

   always_comb begin
      sum = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         eff_w[i] = (weight_in[i*W_W +: W_W] > dep[i]) ? weight_in[i*W_W +: W_W] - dep[i] : '0;
         sum = sum + S_W'(chan_in[i*IN_W +: IN_W]) * S_W'(eff_w[i]);
      end
   end

   // Signed accumulate so a leak larger than v_mem + sum floors cleanly at zero.
   always_comb begin
      nv_s = $signed(N_W'(v_mem)) + $signed(N_W'(sum)) - $signed(N_W'(leak));
      if (nv_s < 0)
         new_v = '0;
      else if (nv_s > $signed(N_W'({V_W{1'b1}})))
         new_v = '1;
      else
         new_v = nv_s[V_W-1:0];
   end

   always_comb begin
      v_leak   = (v_mem > V_W'(leak)) ? v_mem - V_W'(leak) : '0;
      thr_up_w = {1'b0, thr_c} + (V_W+1)'(THR_UP);
      thr_spk  = (thr_up_w > {1'b0, threshold_max}) ? threshold_max : thr_up_w[V_W-1:0];
      thr_lo_w = {1'b0, threshold_min} + (V_W+1)'(THR_DN);
      thr_idle = ({1'b0, thr_c} > thr_lo_w) ? thr_c - V_W'(THR_DN) : threshold_min;
      fire     = step && (refr_cnt == '0) && (new_v >= thr_c);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v_mem       <= '0;
         thr         <= threshold_min;
         refr_cnt    <= '0;
         spike_out   <= 1'b0;
         spike_count <= '0;
         for (int i = 0; i < NUM_CH; i++)
            dep[i] <= '0;
      end else begin
         spike_out <= 1'b0;
         if (step) begin
            thr <= fire ? thr_spk : thr_idle;
            if (refr_cnt != '0) begin
               refr_cnt <= refr_cnt - RC_W'(1);
               v_mem    <= v_leak;
            end else if (fire) begin
               spike_out <= 1'b1;
               refr_cnt  <= RC_W'(REFRAC);
               v_mem     <= reset_mode ? new_v - thr_c : '0;
            end else begin
               v_mem <= new_v;
            end
            for (int i = 0; i < NUM_CH; i++) begin
               if (fire) begin
                  if (chan_in[i*IN_W +: IN_W] != '0)
                     dep[i] <= (({1'b0, dep[i]} + (W_W+1)'(DEP_STEP)) > (W_W+1)'({W_W{1'b1}}))
                               ? '1 : dep[i] + W_W'(DEP_STEP);
               end else if (dep[i] != '0) begin
                  dep[i] <= dep[i] - W_W'(1);
               end
            end
         end
         // A clear that coincides with a spike keeps that spike counted.
         if (count_clr)
            spike_count <= fire ? 8'd1 : 8'd0;
         else if (fire && spike_count != 8'hFF)
            spike_count <= spike_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_lif_neuron_multi.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor
// pops one entry per clock and compares against the selected neuron instance.
module tb_lif_neuron_multi;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        enable_b = 1'b0;
   logic        params_ready = 1'b1;
   logic [11:0] chan_in = '0;
   logic [11:0] weight_in = '0;
   logic [1:0]  leak_config = 2'd0;
   logic        reset_mode = 1'b0;
   logic [9:0]  thr_min = 10'd20;
   logic [9:0]  thr_max = 10'd40;
   logic [7:0]  thr_min_b = 8'd255;
   logic [7:0]  thr_max_b = 8'd255;
   logic        count_clr = 1'b0;

   logic       spk_a, ref_a, spk_b, ref_b;
   logic [9:0] v_a;
   logic [7:0] v_b, cnt_a, cnt_b;

   always #5 clk = ~clk;

   lif_neuron_multi dut_a (
      .clk(clk), .reset(reset), .enable(enable), .params_ready(params_ready),
      .chan_in(chan_in), .weight_in(weight_in), .leak_config(leak_config),
      .reset_mode(reset_mode), .threshold_min(thr_min), .threshold_max(thr_max),
      .count_clr(count_clr), .spike_out(spk_a), .v_mem_out(v_a),
      .refractory(ref_a), .spike_count(cnt_a)
   );

   lif_neuron_multi #(.V_W(8), .REFRAC(0)) dut_b (
      .clk(clk), .reset(reset), .enable(enable_b), .params_ready(params_ready),
      .chan_in(chan_in), .weight_in(weight_in), .leak_config(leak_config),
      .reset_mode(reset_mode), .threshold_min(thr_min_b), .threshold_max(thr_max_b),
      .count_clr(count_clr), .spike_out(spk_b), .v_mem_out(v_b),
      .refractory(ref_b), .spike_count(cnt_b)
   );

   typedef struct {
      bit    chk;
      bit    sel;
      bit    spk;
      int    v;
      bit    rf;
      int    cnt;
      string name;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   initial begin
      exp_t e;
      int   av, ac;
      bit   as, ar;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.chk) begin
               vectors++;
               as = e.sel ? spk_b : spk_a;
               ar = e.sel ? ref_b : ref_a;
               av = e.sel ? int'(v_b) : int'(v_a);
               ac = e.sel ? int'(cnt_b) : int'(cnt_a);
               if (as !== e.spk || ar !== e.rf || av != e.v || ac != e.cnt) begin
                  miscompares++;
                  $display("FAIL %s: got spk=%0d v=%0d ref=%0d cnt=%0d, want spk=%0d v=%0d ref=%0d cnt=%0d",
                           e.name, as, av, ar, ac, e.spk, e.v, e.rf, e.cnt);
               end
            end
         end
      end
   end

   task automatic cyc(input bit rst, input bit ea, input bit eb, input bit pr, input bit clr,
                      input bit chk, input bit sel, input bit spk, input int v, input bit rf,
                      input int cnt, input string name);
      exp_t e;
      @(negedge clk);
      reset        = rst;
      enable       = ea;
      enable_b     = eb;
      params_ready = pr;
      count_clr    = clr;
      e.chk = chk; e.sel = sel; e.spk = spk; e.v = v; e.rf = rf; e.cnt = cnt; e.name = name;
      sb.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic step_a(input bit spk, input int v, input bit rf, input int cnt, input string name);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, spk, v, rf, cnt, name);
   endtask

   task automatic step_b(input bit spk, input int v, input bit rf, input int cnt, input string name);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, spk, v, rf, cnt, name);
   endtask

   int t1_spk [11] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
   int t1_ref [11] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};
   int t1_cnt [11] = '{1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 3};

   initial begin
      // Scenario 1: reset-to-zero, three spikes five steps apart
      weight_in = {4{3'd3}};
      chan_in   = {3'd0, 3'd0, 3'd0, 3'd7};
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, "reset_a");
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0, "reset_b");
      for (int k = 0; k < 11; k++)
         step_a(t1_spk[k][0], 0, t1_ref[k][0], t1_cnt[k], $sformatf("t1_step%0d", k + 1));

      // Scenario 2: subtractive reset, threshold_min 10, hold cycles mid-refractory
      reset_mode = 1'b1;
      thr_min    = 10'd10;
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, "t2_reset");
      step_a(1'b1, 10, 1'b1, 1, "t2_spike");
      step_a(1'b0, 9, 1'b1, 1, "t2_refr1");
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9, 1'b1, 1, "hold_no_params");
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9, 1'b1, 1, "hold_no_enable");
      step_a(1'b0, 8, 1'b1, 1, "t2_refr2");
      step_a(1'b0, 7, 1'b1, 1, "t2_refr3");
      step_a(1'b0, 6, 1'b0, 1, "t2_refr_end");
      step_a(1'b1, 16, 1'b1, 2, "t2_spike2");
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, "reset_mid_refr");
      step_a(1'b1, 10, 1'b1, 1, "after_reset_spike");

      // Scenario 3: V_W=8 membrane saturation
      reset_mode = 1'b0;
      weight_in  = {4{3'd7}};
      chan_in    = {4{3'd7}};
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0, "t3_reset");
      step_b(1'b0, 195, 1'b0, 0, "sat_step1");
      step_b(1'b1, 0, 1'b0, 1, "sat_step2");

      // Scenario 4: depression only on active channels (REFRAC=0 instance)
      reset_mode = 1'b1;
      weight_in  = {4{3'd3}};
      chan_in    = {3'd0, 3'd0, 3'd0, 3'd7};
      thr_min_b  = 8'd20;
      thr_max_b  = 8'd20;
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0, "t4_reset");
      step_b(1'b1, 0, 1'b0, 1, "dep_spike");
      chan_in = {3'd0, 3'd0, 3'd7, 3'd7};
      step_b(1'b1, 0, 1'b0, 2, "dep_select");
      chan_in = {3'd0, 3'd0, 3'd0, 3'd7};
      step_b(1'b0, 0, 1'b0, 2, "dep_chan0_blocked");

      // Scenario 5: zero threshold fires every step; counter saturation and clear
      thr_min_b = 8'd0;
      thr_max_b = 8'd0;
      step_b(1'b1, 0, 1'b0, 3, "thr_clamp_down");
      for (int k = 0; k < 296; k++)
         cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0, "spin");
      step_b(1'b1, 0, 1'b0, 255, "count_saturate");
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1, "clr_with_spike");
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0, "clr_idle");
      step_b(1'b1, 0, 1'b0, 1, "count_after_clr");

      repeat (3) @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending entries, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
